beam_frame_uart_streamer: RTL
=============================

Name: beam_frame_uart_streamer

Overview:
- Downstream of the delay-and-sum beamformer. Captures one frame of 40-bit summed samples while sumflag is high and buffers it in internal RAM.
- After capture, drains the buffer as bytes, LSB byte first, into the UART transmitter (communication) using a start/busy handshake.
- Replaces the ad-hoc store/readout loop at the top level with a clean single-clock block.

Parameters:
- WORD_W, 40, sample width; must be a multiple of 8.
- DEPTH, 540, maximum words per frame.
- ADDR_W, 10, buffer address width; requires 2^ADDR_W >= DEPTH.
- BUSY_TIMEOUT, 4096, cycles to wait for tx_busy to rise after tx_start before retrying the byte.

Ports:
- clk  in  1  system clock (PLL c0).
- areset  in  1  asynchronous active-high reset.
- sample_in  in  WORD_W  summed_value from the beamformer.
- sample_valid  in  1  sumflag; high for one word per cycle during a frame.
- tx_byte  out  8  byte to UART (SW).
- tx_start  out  1  one-cycle start pulse to UART (START).
- tx_busy  in  1  UART TX_BUSY_REG.
- streaming  out  1  high from the first tx_start of a frame until its last byte completes.
- frame_done  out  1  one-cycle pulse after the last byte's busy falls.
- overflow  out  1  sticky; set if the frame exceeded DEPTH. Cleared at the next frame start.
- word_count  out  ADDR_W+1  number of words captured in the current or last frame.

Behaviour:
- Reset (asynchronous, any state): go to IDLE. tx_byte=0, tx_start=0, streaming=0, frame_done=0, overflow=0, word_count=0, all pointers=0. RAM contents are don't-care.
- IDLE:
  - On sample_valid=1: write sample_in to addr 0, set word_count=1, clear overflow, go to CAPTURE. This is the same cycle, so no sample is lost.
- CAPTURE:
  - Each cycle with sample_valid=1 and word_count<DEPTH: write at addr word_count, then word_count++.
  - sample_valid=1 with word_count==DEPTH: word is dropped, overflow=1.
  - sample_valid=0: go to LOAD with rd_ptr=0, byte_idx=0.
- LOAD:
  - Issue a RAM read (1-cycle registered latency). Next cycle latch the word into shift_reg and go to SEND.
- SEND:
  - tx_byte=shift_reg[7:0], tx_start=1 for exactly one cycle, streaming=1, then go to WAIT_HI.
  - tx_byte stays stable until the byte completes.
- WAIT_HI:
  - Wait for tx_busy=1, then go to WAIT_LO.
  - If BUSY_TIMEOUT cycles elapse without it, go back to SEND and resend the same byte.
- WAIT_LO:
  - On tx_busy=0 (sampled in clk, no edge-triggered logic on tx_busy):
    - If byte_idx < WORD_W/8-1: shift_reg >>= 8, byte_idx++, go to SEND.
    - Else if rd_ptr < word_count-1: rd_ptr++, byte_idx=0, go to LOAD.
    - Else: frame_done=1 for one cycle, streaming=0, go to IDLE.
- Input handling outside capture: sample_valid in LOAD/SEND/WAIT_* is ignored. A frame arriving mid-stream is dropped; the buffer is never overwritten while draining.
- Bytes per frame: word_count*(WORD_W/8). With the defaults a full frame is 2700 bytes.
- Simultaneous tx_busy fall and areset: reset wins.

Optional Feature:
- Macro: FRAME_HEADER_EN.
- When defined, each frame is prefixed before data by four bytes: 0xA5, 0x5A, then word_count[7:0], then {5'b0, word_count[ADDR_W:8]} (upper bits zero-padded).
  - Header bytes use the same SEND/WAIT handshake. State HDR precedes the first LOAD.
  - streaming rises at the first header byte.
- When undefined, there is no header and the first byte out is word 0 byte 0.

Test Plan:
- 3-word frame 0x0102030405, 0x1112131415, 0x2122232425; UART model busy for 20 cycles per byte -> 15 bytes in order 05,04,03,02,01,15,...,21; one frame_done; word_count=3.
- 545 consecutive valid words -> word_count=540, overflow=1, exactly 2700 bytes sent, last byte = word 539 byte 4.
- UART model that ignores the first tx_start -> after BUSY_TIMEOUT cycles the same byte is re-sent; total byte count unchanged.
- areset asserted mid-WAIT_LO of byte 7 -> outputs return to 0 immediately; a new 2-word frame then streams 10 bytes correctly.
- sample_valid pulses during streaming -> ignored; output matches the original frame and word_count is unchanged.
- With FRAME_HEADER_EN and a 2-word frame -> bytes A5,5A,02,00 followed by 10 data bytes.

Source files
------------

// File: rtl/beam_frame_uart_streamer.sv
`default_nettype none
// ============================================================================
// Module   : beam_frame_uart_streamer
// Brief    : Buffers one beamformer frame and drains it LSB byte first to a UART.
//            Optional 4-byte frame header enabled by macro FRAME_HEADER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module beam_frame_uart_streamer #(
    parameter int WORD_W       = 40,
    parameter int DEPTH        = 540,
    parameter int ADDR_W       = 10,
    parameter int BUSY_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [WORD_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [7:0]        tx_byte,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              streaming,
    output logic              frame_done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam int              c_bytes     = WORD_W / 8;
    localparam int              c_to_w      = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [7:0]      c_last_byte = 8'(c_bytes - 1);
    localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_HDR, S_LOAD, S_LATCH, S_SEND, S_WAIT_HI, S_WAIT_LO
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_mem [DEPTH];
    logic [WORD_W-1:0]   r_rd_data;
    logic [WORD_W-1:0]   r_shift;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [7:0]          r_byte_idx;
    logic [c_to_w-1:0]   r_wait_cnt;
    logic [7:0]          r_tx_byte;
    logic                r_tx_start;
    logic                r_streaming;
    logic                r_frame_done;
    logic                r_overflow;
    logic [ADDR_W:0]     r_word_count;

    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [ADDR_W:0]     w_next_rd;

    assign tx_byte    = r_tx_byte;
    assign tx_start   = r_tx_start;
    assign streaming  = r_streaming;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign word_count = r_word_count;

    assign w_next_rd  = {1'b0, r_rd_ptr} + (ADDR_W + 1)'(1);

    // The first word of a frame is stored in the same cycle the FSM leaves IDLE.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        if (sample_valid) begin
            if (r_state == S_IDLE) begin
                w_we    = 1'b1;
                w_waddr = '0;
            end else if (r_state == S_CAPTURE && r_word_count < c_depth) begin
                w_we    = 1'b1;
                w_waddr = r_word_count[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= sample_in;
        end
        r_rd_data <= r_mem[r_rd_ptr];
    end

`ifdef FRAME_HEADER_EN
    logic       r_in_hdr;
    logic [7:0] w_hdr_byte;

    always_comb begin
        case (r_byte_idx)
            8'd0:    w_hdr_byte = 8'hA5;
            8'd1:    w_hdr_byte = 8'h5A;
            8'd2:    w_hdr_byte = 8'(r_word_count);
            default: w_hdr_byte = 8'(r_word_count >> 8);
        endcase
    end
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_rd_ptr     <= '0;
            r_byte_idx   <= '0;
            r_wait_cnt   <= '0;
            r_tx_byte    <= '0;
            r_tx_start   <= 1'b0;
            r_streaming  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
`ifdef FRAME_HEADER_EN
            r_in_hdr     <= 1'b0;
`endif
        end else begin
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sample_valid) begin
                        r_word_count <= (ADDR_W + 1)'(1);
                        r_overflow   <= 1'b0;
                        r_state      <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (sample_valid) begin
                        if (r_word_count < c_depth) begin
                            r_word_count <= r_word_count + (ADDR_W + 1)'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_rd_ptr   <= '0;
                        r_byte_idx <= '0;
`ifdef FRAME_HEADER_EN
                        r_in_hdr   <= 1'b1;
                        r_state    <= S_HDR;
`else
                        r_state    <= S_LOAD;
`endif
                    end
                end
`ifdef FRAME_HEADER_EN
                S_HDR: begin
                    r_shift <= WORD_W'(w_hdr_byte);
                    r_state <= S_SEND;
                end
`endif
                S_LOAD: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_shift <= r_rd_data;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    r_tx_byte   <= r_shift[7:0];
                    r_tx_start  <= 1'b1;
                    r_streaming <= 1'b1;
                    r_wait_cnt  <= '0;
                    r_state     <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_wait_cnt == c_to_last) begin
                        r_state <= S_SEND;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_to_w'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
`ifdef FRAME_HEADER_EN
                        if (r_in_hdr) begin
                            if (r_byte_idx < 8'd3) begin
                                r_byte_idx <= r_byte_idx + 8'd1;
                                r_state    <= S_HDR;
                            end else begin
                                r_in_hdr   <= 1'b0;
                                r_byte_idx <= '0;
                                r_state    <= S_LOAD;
                            end
                        end else
`endif
                        if (r_byte_idx < c_last_byte) begin
                            r_shift    <= r_shift >> 8;
                            r_byte_idx <= r_byte_idx + 8'd1;
                            r_state    <= S_SEND;
                        end else if (w_next_rd < r_word_count) begin
                            r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                            r_byte_idx <= '0;
                            r_state    <= S_LOAD;
                        end else begin
                            r_frame_done <= 1'b1;
                            r_streaming  <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
